// File: rtl/sr_pkg.sv
// Shared types and constants for the 16X super-resolution datapath.
// Pixel, coefficient and four-tap bundle definitions used by the interpolation stages.
package sr_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int COEF_WIDTH  = 10;
    localparam int COEF_FRAC   = 7;

    typedef logic [PIXEL_WIDTH-1:0]       pixel_t;
    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    typedef struct packed {
        pixel_t [3:0] pix;
        coef_t  [3:0] coef;
    } tap4_t;

endpackage

// File: rtl/bicubic_pair_mac.sv
// Two pixel-by-weight products (S1) and their pair sum (S2).
// Pure datapath: the parent decides when each register loads.
module bicubic_pair_mac
    import sr_pkg::*;
#(
    parameter int COEF_WIDTH = sr_pkg::COEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         ld_prod,
    input  logic                         ld_sum,
    input  pixel_t                       pix_a,
    input  pixel_t                       pix_b,
    input  logic signed [COEF_WIDTH-1:0] coef_a,
    input  logic signed [COEF_WIDTH-1:0] coef_b,
    output logic signed [COEF_WIDTH+9:0] sum
);

    localparam int PW = 9 + COEF_WIDTH;

    logic signed [PW-1:0] prod_a;
    logic signed [PW-1:0] prod_b;

    // Pixels are unsigned, so zero-extend to 9 bits before the signed multiply.
    always_ff @(posedge clk) begin
        if (ld_prod) begin
            prod_a <= PW'($signed({1'b0, pix_a})) * PW'(coef_a);
            prod_b <= PW'($signed({1'b0, pix_b})) * PW'(coef_b);
        end
    end

    always_ff @(posedge clk) begin
        if (ld_sum) begin
            sum <= (PW+1)'(prod_a) + (PW+1)'(prod_b);
        end
    end

endmodule

// File: rtl/bicubic_tap_mac.sv
// Four-tap bicubic MAC: 3 register stages, per-stage valid with bubble collapse.
// Define BICUBIC_MAC_ROUND_EN to round half up before the de-scale shift (floor otherwise).
module bicubic_tap_mac
    import sr_pkg::*;
#(
    parameter int COEF_WIDTH = sr_pkg::COEF_WIDTH,
    parameter int COEF_FRAC  = sr_pkg::COEF_FRAC,
    parameter int OUT_WIDTH  = 11,
    parameter int USER_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  pixel_t [3:0]                in_pix,
    input  logic [3:0][COEF_WIDTH-1:0]  in_coef,
    input  logic                        in_last,
    input  logic [USER_WIDTH-1:0]       in_user,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic [USER_WIDTH-1:0]       out_user
);

    localparam int PW      = 9 + COEF_WIDTH;
    localparam int SW      = PW + 2;
    localparam int SAT_MAX = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_WIDTH - 1));

    // Handshake: a beat moves across a port on any cycle where valid && ready.
    // Stage k is ready when empty or when its occupant leaves this cycle; readiness
    // ripples back from out_ready, so in_ready never depends on in_valid.
    logic v1, v2, v3;
    logic r1, r2, r3;
    logic ld1, ld2, ld3;

    assign r3       = !v3 || out_ready;
    assign r2       = !v2 || r3;
    assign r1       = !v1 || r2;
    assign ld1      = r1 && in_valid;
    assign ld2      = r2 && v1;
    assign ld3      = r3 && v2;
    assign in_ready = r1;
    assign out_valid = v3;

    logic                  last1, last2;
    logic [USER_WIDTH-1:0] user1, user2;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
            user1 <= '0;
            user2 <= '0;
        end else begin
            if (r1) v1 <= in_valid;
            if (r2) v2 <= v1;
            if (r3) v3 <= v2;
            if (ld1) begin
                last1 <= in_last;
                user1 <= in_user;
            end
            if (ld2) begin
                last2 <= last1;
                user2 <= user1;
            end
        end
    end

    logic signed [PW:0] sum_a;
    logic signed [PW:0] sum_b;

    bicubic_pair_mac #(.COEF_WIDTH(COEF_WIDTH)) u_pair_lo (
        .clk     (clk),
        .ld_prod (ld1),
        .ld_sum  (ld2),
        .pix_a   (in_pix[0]),
        .pix_b   (in_pix[1]),
        .coef_a  ($signed(in_coef[0])),
        .coef_b  ($signed(in_coef[1])),
        .sum     (sum_a)
    );

    bicubic_pair_mac #(.COEF_WIDTH(COEF_WIDTH)) u_pair_hi (
        .clk     (clk),
        .ld_prod (ld1),
        .ld_sum  (ld2),
        .pix_a   (in_pix[2]),
        .pix_b   (in_pix[3]),
        .coef_a  ($signed(in_coef[2])),
        .coef_b  ($signed(in_coef[3])),
        .sum     (sum_b)
    );

`ifdef BICUBIC_MAC_ROUND_EN
    localparam int RND = 1 << (COEF_FRAC - 1);
`endif

    logic signed [SW-1:0]        sum_full;
    logic signed [SW-1:0]        sum_rnd;
    logic signed [SW-1:0]        sum_shr;
    logic signed [OUT_WIDTH-1:0] sat;

    // Saturation only matters for non-normalized weights; normal kernels stay in range.
    always_comb begin
        sum_full = SW'(sum_a) + SW'(sum_b);
`ifdef BICUBIC_MAC_ROUND_EN
        sum_rnd  = sum_full + SW'(RND);
`else
        sum_rnd  = sum_full;
`endif
        sum_shr  = sum_rnd >>> COEF_FRAC;
        if (sum_shr > SW'(SAT_MAX)) begin
            sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (sum_shr < SW'(SAT_MIN)) begin
            sat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat = sum_shr[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_data <= '0;
            out_last <= 1'b0;
            out_user <= '0;
        end else if (ld3) begin
            out_data <= sat;
            out_last <= last2;
            out_user <= user2;
        end
    end

endmodule

// File: tb/tb_bicubic_tap_mac.sv
// Directed bench for bicubic_tap_mac: latency, arithmetic corner cases, stall and reset.
// Expected values follow the BICUBIC_MAC_ROUND_EN setting of the build.
module tb_bicubic_tap_mac;
    import sr_pkg::*;

    logic               clk;
    logic               aresetn;
    logic               in_valid;
    logic               in_ready;
    pixel_t [3:0]       in_pix;
    logic [3:0][9:0]    in_coef;
    logic               in_last;
    logic [0:0]         in_user;
    logic               out_valid;
    logic               out_ready;
    logic [10:0]        out_data;
    logic               out_last;
    logic [0:0]         out_user;

    int compared;
    int mismatched;
    logic [10:0] exp_q[$];

    bicubic_tap_mac #(
        .COEF_WIDTH (10),
        .COEF_FRAC  (7),
        .OUT_WIDTH  (11),
        .USER_WIDTH (1)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_coef   (in_coef),
        .in_last   (in_last),
        .in_user   (in_user),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_user  (out_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tap4_t mk(input int p0, input int p1, input int p2, input int p3,
                                 input int c0, input int c1, input int c2, input int c3);
        tap4_t t;
        t.pix[0]  = 8'(p0);
        t.pix[1]  = 8'(p1);
        t.pix[2]  = 8'(p2);
        t.pix[3]  = 8'(p3);
        t.coef[0] = coef_t'(c0);
        t.coef[1] = coef_t'(c1);
        t.coef[2] = coef_t'(c2);
        t.coef[3] = coef_t'(c3);
        return t;
    endfunction

    // Sends one beat from a negedge, then reports the result and the cycles it took.
    task automatic drive_single(input tap4_t t, input logic last, input logic [0:0] user,
                                output logic [10:0] data, output int lat,
                                output logic olast, output logic [0:0] ouser);
        in_pix    = t.pix;
        in_coef   = t.coef;
        in_last   = last;
        in_user   = user;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            lat++;
        end
        data  = out_data;
        olast = out_last;
        ouser = out_user;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        aresetn   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_pix    = '0;
        in_coef   = '0;
        in_last   = 1'b0;
        in_user   = '0;
        #3;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        compared++;
        if (out_data !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_out_data: got %0d want 0", $signed(out_data));
        end
        compared++;
        if (out_last !== 1'b0 || out_user !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_sideband: got last=%b user=%b want 0/0", out_last, out_user);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_identity;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
        drive_single(mk(10, 200, 30, 40, 0, 128, 0, 0), 1'b1, 1'b1, d, lat, l, u);
        compared++;
        if (lat !== 3) begin
            mismatched++;
            $display("FAIL identity_latency: got %0d want 3", lat);
        end
        compared++;
        if (d !== 11'(200)) begin
            mismatched++;
            $display("FAIL identity_data: got %0d want 200", $signed(d));
        end
        compared++;
        if (l !== 1'b1 || u !== 1'b1) begin
            mismatched++;
            $display("FAIL identity_sideband: got last=%b user=%b want 1/1", l, u);
        end
    endtask

    task automatic test_overshoot;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
`ifdef BICUBIC_MAC_ROUND_EN
        int exp_v = 287;
`else
        int exp_v = 286;
`endif
        drive_single(mk(0, 255, 0, 0, -16, 144, 0, 0), 1'b0, 1'b0, d, lat, l, u);
        compared++;
        if (d !== 11'(exp_v) || lat !== 3) begin
            mismatched++;
            $display("FAIL overshoot: got %0d lat %0d want %0d lat 3", $signed(d), lat, exp_v);
        end
        compared++;
        if (l !== 1'b0 || u !== 1'b0) begin
            mismatched++;
            $display("FAIL overshoot_sideband: got last=%b user=%b want 0/0", l, u);
        end
    endtask

    task automatic test_undershoot;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
        drive_single(mk(255, 0, 0, 0, -16, 144, 0, 0), 1'b0, 1'b0, d, lat, l, u);
        compared++;
        if (d !== 11'(-32)) begin
            mismatched++;
            $display("FAIL undershoot: got %0d want -32", $signed(d));
        end
    endtask

    task automatic test_rounding;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
`ifdef BICUBIC_MAC_ROUND_EN
        int exp_v = 2;
`else
        int exp_v = 1;
`endif
        drive_single(mk(0, 3, 0, 0, 0, 64, 64, 0), 1'b0, 1'b0, d, lat, l, u);
        compared++;
        if (d !== 11'(exp_v)) begin
            mismatched++;
            $display("FAIL rounding: got %0d want %0d", $signed(d), exp_v);
        end
    endtask

    task automatic test_four_tap;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
        // -900 + 8760 + 10220 - 1440 = 16640 = 130 * 128 exactly
        drive_single(mk(100, 120, 140, 160, -9, 73, 73, -9), 1'b0, 1'b1, d, lat, l, u);
        compared++;
        if (d !== 11'(130) || u !== 1'b1) begin
            mismatched++;
            $display("FAIL four_tap: got %0d user %b want 130 user 1", $signed(d), u);
        end
    endtask

    task automatic test_saturation;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
        // 4*255*511/128 = 4072 -> clamps to 1023
        drive_single(mk(255, 255, 255, 255, 511, 511, 511, 511), 1'b0, 1'b0, d, lat, l, u);
        compared++;
        if (d !== 11'(1023)) begin
            mismatched++;
            $display("FAIL sat_high: got %0d want 1023", $signed(d));
        end
        // 4*255*(-512)/128 = -4080 -> clamps to -1024
        drive_single(mk(255, 255, 255, 255, -512, -512, -512, -512), 1'b0, 1'b0, d, lat, l, u);
        compared++;
        if (d !== 11'(-1024)) begin
            mismatched++;
            $display("FAIL sat_low: got %0d want -1024", $signed(d));
        end
    endtask

    task automatic test_back_to_back_stall;
        tap4_t beats[8];
        int sent, recv, cyc;
        logic acc_in, acc_out, holding, held_l;
        logic [10:0] held_d, exp_v;
        // Beat k passes tap (k % 4) with unity weight; pixel on tap s is 20*(s+1)+k.
        for (int k = 0; k < 8; k++) begin
            beats[k] = mk(20 + k, 40 + k, 60 + k, 80 + k,
                          (k % 4 == 0) ? 128 : 0, (k % 4 == 1) ? 128 : 0,
                          (k % 4 == 2) ? 128 : 0, (k % 4 == 3) ? 128 : 0);
        end
        exp_q = {};
        exp_q.push_back(11'd20);
        exp_q.push_back(11'd41);
        exp_q.push_back(11'd62);
        exp_q.push_back(11'd83);
        exp_q.push_back(11'd24);
        exp_q.push_back(11'd45);
        exp_q.push_back(11'd66);
        exp_q.push_back(11'd87);
        sent = 0;
        recv = 0;
        cyc = 0;
        holding = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (recv < 8 && cyc < 80) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_pix  = beats[sent].pix;
                in_coef = beats[sent].coef;
                in_last = (sent == 7);
                in_user = 1'(sent % 2);
            end
            #1;
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (cyc >= 3 && cyc < 8) begin
                compared++;
                if (in_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_in_ready cyc %0d: got %b want 0", cyc, in_ready);
                end
            end
            if (holding) begin
                compared++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    mismatched++;
                    $display("FAIL stall_hold cyc %0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                             cyc, out_valid, $signed(out_data), out_last, $signed(held_d), held_l);
                end
            end
            if (acc_out) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7ff;
                compared++;
                if (out_data !== exp_v || out_last !== (recv == 7) || out_user !== 1'(recv % 2)) begin
                    mismatched++;
                    $display("FAIL stream_beat %0d: got d=%0d l=%b u=%b want d=%0d l=%b u=%b",
                             recv, $signed(out_data), out_last, out_user, $signed(exp_v),
                             (recv == 7), 1'(recv % 2));
                end
                recv++;
            end
            holding = out_valid && !out_ready;
            held_d  = out_data;
            held_l  = out_last;
            if (acc_in) sent++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        compared++;
        if (recv != 8 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL stream_count: got %0d beats want 8 (timeout or loss)", recv);
        end
    endtask

    task automatic test_reset_mid;
        int stale;
        logic [10:0] d;
        int lat;
        logic l;
        logic [0:0] u;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pix    = mk(50, 60, 70, 80, 128, 0, 0, 0).pix;
        in_coef   = mk(50, 60, 70, 80, 128, 0, 0, 0).coef;
        @(posedge clk);
        @(negedge clk);
        in_pix    = mk(50, 60, 70, 80, 0, 0, 0, 128).pix;
        in_coef   = mk(50, 60, 70, 80, 0, 0, 0, 128).coef;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_pre_valid: got %b want 1", out_valid);
        end
        aresetn = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 11'd0) begin
            mismatched++;
            $display("FAIL midrst_clear: got v=%b d=%0d want v=0 d=0", out_valid, $signed(out_data));
        end
        @(negedge clk);
        aresetn   = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        compared++;
        if (stale != 0) begin
            mismatched++;
            $display("FAIL midrst_stale: got %0d valid cycles want 0", stale);
        end
        drive_single(mk(10, 200, 30, 40, 0, 128, 0, 0), 1'b0, 1'b0, d, lat, l, u);
        compared++;
        if (d !== 11'(200) || lat !== 3) begin
            mismatched++;
            $display("FAIL midrst_recover: got d=%0d lat=%0d want d=200 lat=3", $signed(d), lat);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_identity();
        test_overshoot();
        test_undershoot();
        test_rounding();
        test_four_tap();
        test_saturation();
        test_back_to_back_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
